// File: rtl/draw_sequencer.sv
// draw_sequencer: frame-level draw scheduler for the VGA pixel path.
//
// On each frame_tick the enabled layers (latched from layer_en) are walked in
// ascending index order. Each layer gets a one-cycle go pulse, then the
// sequencer waits for that drawer's done (or a watchdog expiry) before moving
// on. While a layer is active, pixel_sel holds its index and that drawer's
// plot strobe is forwarded to the VGA write enable.
//
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   frame_tick        - one-cycle request to redraw a frame
//   layer_en          - per-layer enable, sampled on the accepted frame_tick
//   layer_done        - per-drawer done (pulse or level), sampled only in WAIT
//   layer_plot        - per-drawer pixel-valid strobe
//   layer_go          - one-hot one-cycle start pulse to the active drawer
//   pixel_sel         - pixel mux select (active layer index, 0 when idle)
//   plot              - VGA write enable
//   busy              - frame in progress
//   frame_done        - one-cycle pulse when a frame completes
//   overrun           - pulses the cycle after a frame_tick arrives while busy
//   timeout_err       - pulses in the cycle a layer is force-advanced
module draw_sequencer #(
    parameter int NUM_LAYERS = 9,
    parameter int SEL_W      = 5,
    parameter int TIMEOUT    = 20000,
    parameter int TMR_W      = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_tick,
    input  logic [NUM_LAYERS-1:0] layer_en,
    input  logic [NUM_LAYERS-1:0] layer_done,
    input  logic [NUM_LAYERS-1:0] layer_plot,
    output logic [NUM_LAYERS-1:0] layer_go,
    output logic [SEL_W-1:0]      pixel_sel,
    output logic                  plot,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  overrun,
    output logic                  timeout_err
);
    localparam int IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_FINISH} state_t;

    state_t                  state_q, state_d;
    logic [NUM_LAYERS-1:0]   en_q, en_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [TMR_W-1:0]        wdog_q, wdog_d;
    logic                    overrun_q, overrun_d;

    logic [NUM_LAYERS-1:0]   search_mask;
    logic [IDX_W-1:0]        search_idx;
    logic                    search_found;
    logic                    cur_done, cur_plot, wdog_expired;

    // Next-layer priority encoder. In IDLE the mask being latched this cycle
    // is searched from bit 0; otherwise only bits strictly above idx count.
    // Descending loop so the lowest qualifying bit is the last one written.
    always_comb begin
        search_mask  = (state_q == S_IDLE) ? layer_en : en_q;
        search_idx   = '0;
        search_found = 1'b0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (search_mask[i] && (state_q == S_IDLE || i > int'(idx_q))) begin
                search_idx   = IDX_W'(i);
                search_found = 1'b1;
            end
        end
    end

    // Only the active layer's done/plot are visible; all others are ignored.
    always_comb begin
        cur_done = 1'b0;
        cur_plot = 1'b0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (int'(idx_q) == i) begin
                cur_done = layer_done[i];
                cur_plot = layer_plot[i];
            end
        end
    end

    assign wdog_expired = (wdog_q == TMR_W'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            en_q      <= '0;
            idx_q     <= '0;
            wdog_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            en_q      <= en_d;
            idx_q     <= idx_d;
            wdog_q    <= wdog_d;
            overrun_q <= overrun_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        en_d      = en_q;
        idx_d     = idx_q;
        wdog_d    = wdog_q;
        overrun_d = frame_tick && (state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (frame_tick) begin
                    en_d = layer_en;
                    if (search_found) begin
                        idx_d   = search_idx;
                        state_d = S_START;
                    end else begin
                        state_d = S_FINISH;
                    end
                end
            end
            S_START: begin
                wdog_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                wdog_d = wdog_q + TMR_W'(1);
                // A watchdog expiry advances exactly like a done.
                if (cur_done || wdog_expired) begin
                    if (search_found) begin
                        idx_d   = search_idx;
                        state_d = S_START;
                    end else begin
                        state_d = S_FINISH;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        layer_go    = '0;
        pixel_sel   = '0;
        plot        = 1'b0;
        busy        = (state_q != S_IDLE);
        frame_done  = (state_q == S_FINISH);
        timeout_err = 1'b0;
        overrun     = overrun_q;
        case (state_q)
            S_START: begin
                pixel_sel = SEL_W'(idx_q);
                for (int i = 0; i < NUM_LAYERS; i++) begin
                    layer_go[i] = (int'(idx_q) == i);
                end
            end
            S_WAIT: begin
                pixel_sel   = SEL_W'(idx_q);
                plot        = cur_plot;
                timeout_err = wdog_expired && !cur_done;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_draw_sequencer.sv
module tb_draw_sequencer;
    localparam int NL   = 9;
    localparam int SW   = 5;
    localparam int TO   = 16;
    localparam int TW   = 15;
    localparam int MAXC = 256;

    logic          clk = 1'b0;
    logic          reset, frame_tick;
    logic [NL-1:0] layer_en, layer_done, layer_plot, layer_go;
    logic [SW-1:0] pixel_sel;
    logic          plot, busy, frame_done, overrun, timeout_err;

    int checks = 0;
    int errors = 0;

    // Expected per-cycle trace of one frame (cycle 0 = tick cycle).
    int e_go[MAXC];   // layer pulsed with go, -1 none
    int e_sel[MAXC];
    int e_wl[MAXC];   // layer whose plot/done is live (waiting), -1 none
    int e_dn[MAXC];   // layer whose drawer reports done this cycle, -1 none
    bit e_busy[MAXC], e_fd[MAXC], e_to[MAXC], e_ov[MAXC];
    int d_lat[NL];    // cycles from go to done; > TO means the drawer hangs

    always #5 clk = ~clk;

    draw_sequencer #(.NUM_LAYERS(NL), .SEL_W(SW), .TIMEOUT(TO), .TMR_W(TW)) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .layer_en(layer_en), .layer_done(layer_done), .layer_plot(layer_plot),
        .layer_go(layer_go), .pixel_sel(pixel_sel), .plot(plot), .busy(busy),
        .frame_done(frame_done), .overrun(overrun), .timeout_err(timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Frame timeline from the scheduling rules: first go 1 cycle after the
    // tick; layer waits min(latency, TO) cycles; next go the cycle after;
    // frame_done the cycle after the last layer ends; then one idle cycle.
    task automatic build(input logic [NL-1:0] mask, output int n);
        int t, d;
        for (int c = 0; c < MAXC; c++) begin
            e_go[c] = -1; e_sel[c] = 0; e_wl[c] = -1; e_dn[c] = -1;
            e_busy[c] = 0; e_fd[c] = 0; e_to[c] = 0; e_ov[c] = 0;
        end
        t = 1;
        for (int i = 0; i < NL; i++) begin
            if (mask[i]) begin
                e_go[t] = i; e_sel[t] = i; e_busy[t] = 1;
                d = (d_lat[i] > TO) ? TO : d_lat[i];
                if (d_lat[i] <= TO) e_dn[t + d] = i;
                else                e_to[t + d] = 1;
                for (int k = 1; k <= d; k++) begin
                    e_sel[t + k] = i; e_wl[t + k] = i; e_busy[t + k] = 1;
                end
                t = t + d + 1;
            end
        end
        e_fd[t] = 1; e_busy[t] = 1;
        n = t + 2;
    endtask

    // ov_layer: extra frame_tick on the 2nd waiting cycle of that layer.
    // rst_layer: reset on the 2nd waiting cycle of that layer, frame aborted.
    task automatic run(input logic [NL-1:0] mask, input int ov_layer, input int rst_layer,
                       input bit noise);
        int n, xt, rt;
        logic [NL-1:0] dn;
        build(mask, n);
        xt = -1; rt = -1;
        for (int c = MAXC - 1; c >= 0; c--) begin
            if (ov_layer >= 0 && e_wl[c] == ov_layer) xt = c + 1;
            if (rst_layer >= 0 && e_wl[c] == rst_layer) rt = c + 1;
        end
        if (xt > 0) e_ov[xt + 1] = 1;
        if (rt > 0) n = rt + 2;
        for (int t = 0; t < n; t++) begin
            @(negedge clk);
            frame_tick = (t == 0) || (t == xt);
            layer_en   = (t == 0) ? mask : NL'($urandom);
            reset      = (t == rt);
            layer_plot = NL'($urandom);
            dn = noise ? NL'($urandom) : '0;
            if (e_wl[t] >= 0) dn = dn & ~NL'(1 << e_wl[t]);
            if (e_dn[t] >= 0) dn = dn | NL'(1 << e_dn[t]);
            layer_done = dn;
            #1;
            if (rt > 0 && t == rt + 1) begin
                chk($sformatf("rst_go t=%0d", t),    32'(layer_go),    32'd0);
                chk($sformatf("rst_sel t=%0d", t),   32'(pixel_sel),   32'd0);
                chk($sformatf("rst_plot t=%0d", t),  32'(plot),        32'd0);
                chk($sformatf("rst_busy t=%0d", t),  32'(busy),        32'd0);
                chk($sformatf("rst_fd t=%0d", t),    32'(frame_done),  32'd0);
                chk($sformatf("rst_to t=%0d", t),    32'(timeout_err), 32'd0);
                chk($sformatf("rst_ov t=%0d", t),    32'(overrun),     32'd0);
            end else begin
                chk($sformatf("go t=%0d", t),   32'(layer_go),
                    (e_go[t] >= 0) ? (32'd1 << e_go[t]) : 32'd0);
                chk($sformatf("sel t=%0d", t),  32'(pixel_sel), 32'(e_sel[t]));
                chk($sformatf("plot t=%0d", t), 32'(plot),
                    (e_wl[t] >= 0) ? ((32'(layer_plot) >> e_wl[t]) & 32'd1) : 32'd0);
                chk($sformatf("busy t=%0d", t), 32'(busy),        32'(e_busy[t]));
                chk($sformatf("fd t=%0d", t),   32'(frame_done),  32'(e_fd[t]));
                chk($sformatf("to t=%0d", t),   32'(timeout_err), 32'(e_to[t]));
                chk($sformatf("ov t=%0d", t),   32'(overrun),     32'(e_ov[t]));
            end
        end
        @(negedge clk);
        frame_tick = 0; reset = 0; layer_done = '0; layer_plot = '0;
    endtask

    initial begin
        reset = 1; frame_tick = 0; layer_en = '0; layer_done = '0; layer_plot = '1;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_go",   32'(layer_go),    32'd0);
        chk("reset_sel",  32'(pixel_sel),   32'd0);
        chk("reset_plot", 32'(plot),        32'd0);
        chk("reset_busy", 32'(busy),        32'd0);
        chk("reset_fd",   32'(frame_done),  32'd0);
        chk("reset_ov",   32'(overrun),     32'd0);
        chk("reset_to",   32'(timeout_err), 32'd0);
        @(negedge clk);
        reset = 0;

        // All layers, done 3 cycles after each go.
        for (int i = 0; i < NL; i++) d_lat[i] = 3;
        run(9'h1FF, -1, -1, 1'b0);

        // Sparse mask with junk done bits on inactive layers.
        for (int i = 0; i < NL; i++) d_lat[i] = 1 + int'($urandom_range(7));
        run(9'b100010001, -1, -1, 1'b1);

        // Empty mask.
        run(9'h000, -1, -1, 1'b1);

        // Layer 2 hangs: watchdog forces the advance.
        for (int i = 0; i < NL; i++) d_lat[i] = 2;
        d_lat[2] = 1000;
        run(9'h1FF, -1, -1, 1'b0);

        // Done landing on the watchdog's last cycle wins over the timeout.
        d_lat[2] = TO;
        run(9'h00C, -1, -1, 1'b1);

        // Overrun: second tick while layer 5 is waiting.
        for (int i = 0; i < NL; i++) d_lat[i] = 4;
        d_lat[5] = 6;
        run(9'h1FF, 5, -1, 1'b1);

        // Reset while layer 3 is waiting, then a clean restart.
        d_lat[3] = 6;
        run(9'h1FF, -1, 3, 1'b1);
        run(9'h1FF, -1, -1, 1'b0);

        // Random frames, some layers hanging past the watchdog.
        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < NL; i++) d_lat[i] = 1 + int'($urandom_range(17));
            run(NL'($urandom), (f == 3) ? 8 : -1, -1, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/draw_sequencer.md
Name: draw_sequencer

Overview:
- Frame-level draw scheduler that produces the 5-bit pixel_sel consumed by the VGA pixel output mux.
- On each frame tick it walks the drawing layers in priority order: background, sidebar, plate, cherry, cake1, cake2, cake3, score, game_over.
- It starts each enabled drawer with a one-cycle go pulse and waits for that drawer's done.
- While a layer is active, it holds pixel_sel at that layer's index and forwards that drawer's plot strobe to the VGA adapter write enable.

Parameters:
- NUM_LAYERS, 9, number of drawer layers; index i equals the mux select code for that layer.
- SEL_W, 5, width of pixel_sel.
- TIMEOUT, 20000, maximum cycles a layer may stay active before being force-advanced. Exceeds 160x120 = 19200 background pixels.
- TMR_W, 15, width of the per-layer watchdog counter; must hold TIMEOUT-1.

Ports:
- clk, in, 1, system clock.
- reset, in, 1, synchronous active-high reset.
- frame_tick, in, 1, one-cycle pulse requesting a new frame redraw.
- layer_en, in, NUM_LAYERS, bit i set = draw layer i this frame.
- layer_done, in, NUM_LAYERS, per-drawer done pulse or level.
- layer_plot, in, NUM_LAYERS, per-drawer pixel-valid strobe.
- layer_go, out, NUM_LAYERS, one-hot one-cycle start pulse to drawer i.
- pixel_sel, out, SEL_W, select code for the pixel output mux.
- plot, out, 1, VGA write enable.
- busy, out, 1, high while a frame is in progress.
- frame_done, out, 1, one-cycle pulse when a frame completes.
- overrun, out, 1, one-cycle pulse when frame_tick arrives while not IDLE.
- timeout_err, out, 1, one-cycle pulse when a layer is force-advanced.

Behaviour:
- Reset:
  - All registered outputs are 0, state is IDLE, layer index is 0, watchdog is 0.
  - Reset asserted mid-frame aborts the frame; no go, frame_done or error pulses are produced.
- States: IDLE, START, WAIT, FINISH.
- IDLE:
  - pixel_sel = 0, plot = 0, busy = 0.
  - On frame_tick, latch layer_en into en_q. Later changes to layer_en have no effect until the next frame.
  - If en_q == 0, go to FINISH. Otherwise set idx to the lowest set bit of en_q and go to START.
- START (1 cycle):
  - layer_go[idx] = 1, all other go bits 0.
  - pixel_sel = idx, plot = 0, watchdog cleared.
  - Next state is WAIT.
- WAIT:
  - pixel_sel = idx.
  - plot = layer_plot[idx], combinational, so a pixel and its strobe align in the same cycle.
  - Watchdog increments each cycle.
  - layer_done[idx] high: compute the next set bit of en_q above idx. If one exists, set idx to it and go to START; otherwise go to FINISH.
  - Watchdog == TIMEOUT-1 without done: pulse timeout_err and advance exactly as if done had occurred.
  - Done and timeout in the same cycle: treat as done; no timeout_err.
  - layer_done and layer_plot bits for inactive layers are ignored in all states.
  - layer_done is sampled only in WAIT, so a drawer's done in its START cycle is ignored. Drawers take at least 1 cycle.
- FINISH (1 cycle):
  - frame_done = 1, pixel_sel = 0, plot = 0.
  - Next state is IDLE.
- busy = 1 in START, WAIT and FINISH.
- frame_tick in any state other than IDLE is dropped and pulses overrun the following cycle. The frame in progress is unaffected.
- Layer order is strictly ascending index. Each enabled layer is started exactly once per frame.
- Latency:
  - frame_tick to first layer_go: 1 cycle.
  - done to next layer_go: 1 cycle.
  - Last done to frame_done: 1 cycle.
  - Empty mask: frame_done 1 cycle after tick.
- Next-set-bit search is a combinational priority encoder over en_q masked above idx. If no such bit exists, the search result is "none".

Test Plan:
- Reset, then layer_en=9'h1FF, tick at cycle 0; each drawer asserts done 3 cycles after its go.
  - Required: go pulses for layers 0..8 in order.
  - Required: pixel_sel steps 0,1,...,8.
  - Required: frame_done exactly 1 cycle after layer 8's done.
  - Required: busy high throughout.
- layer_en=9'b100010001, tick.
  - Required: only go[0], go[4], go[8] fire.
  - Required: pixel_sel takes 0, then 4, then 8.
  - Required: layer_plot[3] toggling while idx=4 never reaches plot.
- layer_en=0, tick.
  - Required: no go pulses.
  - Required: frame_done 1 cycle after tick, busy high for that single cycle.
- Layer 2 never asserts done, TIMEOUT overridden to 16.
  - Required: timeout_err pulses on layer 2's 16th WAIT cycle.
  - Required: go[3] follows on the next cycle.
  - Required: the frame still completes.
- Second frame_tick while in WAIT of layer 5.
  - Required: overrun pulses 1 cycle later.
  - Required: sequence and idx unchanged.
  - Required: exactly one frame_done.
- reset asserted during WAIT of layer 3.
  - Required: the next cycle shows pixel_sel=0, plot=0, busy=0, no frame_done.
  - Required: a new tick restarts from layer 0.
